// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD mm:ss countdown timer: FSM state encoding,
// per-digit maxima and a small helper for spotting the last second.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] SEC_O_MAX = 4'd9;
  localparam logic [3:0] MIN_T_MAX = 4'd5;
  localparam logic [3:0] MIN_O_MAX = 4'd9;

  // True when the count reads 00:01, i.e. the next decrement lands on 00:00.
  function automatic logic is_last_second(input logic [3:0] mt, input logic [3:0] mo,
                                          input logic [3:0] st, input logic [3:0] so);
    return (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);
  endfunction

endpackage

// File: rtl/dcb_digit.sv
// Single BCD down-counting digit with load, decrement enable and borrow flag.
// Optional macro BCD_COUNTDOWN_LOAD_CLAMP_EN clamps load values above MAX to MAX;
// without it load values are stored verbatim and only the borrow wrap uses MAX.
module dcb_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  logic [3:0] r_digit;
  logic [3:0] w_load_val;

`ifdef BCD_COUNTDOWN_LOAD_CLAMP_EN
  assign w_load_val = (i_load_val > MAX) ? MAX : i_load_val;
`else
  assign w_load_val = i_load_val;
`endif

  // A digit at zero borrows from its neighbour when decremented.
  assign o_borrow = (r_digit == 4'd0);
  assign o_digit  = r_digit;

  // Digit register: load has priority over decrement; zero wraps to MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= w_load_val;
    end else if (i_dec) begin
      r_digit <= o_borrow ? MAX : (r_digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD mm:ss countdown timer with load, pause/resume and a timed
// alarm. Optional macro BCD_COUNTDOWN_LOAD_CLAMP_EN (handled in dcb_digit)
// clamps out-of-range load digits. ALARM_TICKS = 0 holds the alarm until ack.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int TICK_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load_en,
  input  logic [3:0] i_load_mt,
  input  logic [3:0] i_load_mo,
  input  logic [3:0] i_load_st,
  input  logic [3:0] i_load_so,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_ack,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_o,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_o,
  output logic       o_running,
  output logic       o_alarm,
  output logic       o_done_p,
  output logic       o_zero
);

  localparam logic [TICK_W-1:0] ALARM_LIM  = TICK_W'(ALARM_TICKS);
  localparam logic              ALARM_AUTO = (ALARM_TICKS != 0);

  state_t              r_state;
  logic                r_running;
  logic                r_alarm;
  logic                r_done_p;
  logic [TICK_W-1:0]   r_alarm_cnt;

  logic                w_load;
  logic                w_dec;
  logic                w_dec_st;
  logic                w_dec_mo;
  logic                w_dec_mt;
  logic                w_borrow_so;
  logic                w_borrow_st;
  logic                w_borrow_mo;
  logic                w_borrow_mt;
  logic                w_zero;
  logic                w_last;
  logic [TICK_W-1:0]   w_cnt_inc;
  logic                w_alarm_expire;

  // Loads are accepted everywhere except RUN; a tick decrements only in RUN
  // and only when pause is not requested in the same cycle.
  assign w_load = i_load_en && (r_state != RUN);
  assign w_dec  = (r_state == RUN) && i_tick && !i_pause;

  // Borrow chain: each higher digit steps only when every lower digit wraps.
  assign w_dec_st = w_dec    && w_borrow_so;
  assign w_dec_mo = w_dec_st && w_borrow_st;
  assign w_dec_mt = w_dec_mo && w_borrow_mo;

  assign w_zero = w_borrow_so && w_borrow_st && w_borrow_mo && w_borrow_mt;
  assign w_last = is_last_second(o_min_t, o_min_o, o_sec_t, o_sec_o);

  assign w_cnt_inc      = r_alarm_cnt + {{(TICK_W-1){1'b0}}, 1'b1};
  assign w_alarm_expire = ALARM_AUTO && i_tick && (w_cnt_inc == ALARM_LIM);

  dcb_digit #(.MAX(SEC_O_MAX)) u_sec_o (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(i_load_so),
    .i_dec(w_dec), .o_digit(o_sec_o), .o_borrow(w_borrow_so)
  );
  dcb_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(i_load_st),
    .i_dec(w_dec_st), .o_digit(o_sec_t), .o_borrow(w_borrow_st)
  );
  dcb_digit #(.MAX(MIN_O_MAX)) u_min_o (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(i_load_mo),
    .i_dec(w_dec_mo), .o_digit(o_min_o), .o_borrow(w_borrow_mo)
  );
  dcb_digit #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(i_load_mt),
    .i_dec(w_dec_mt), .o_digit(o_min_t), .o_borrow(w_borrow_mt)
  );

  // Control FSM with registered running/alarm/done_p flags and alarm timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
      r_done_p    <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_done_p <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_load_en && i_start && !w_zero) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (i_pause) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end else if (i_tick && w_last) begin
            r_state     <= DONE;
            r_running   <= 1'b0;
            r_alarm     <= 1'b1;
            r_done_p    <= 1'b1;
            r_alarm_cnt <= '0;
          end
        end
        PAUSED: begin
          if (!i_load_en && i_start && !i_pause) begin
            if (w_zero) begin
              r_state <= IDLE;
            end else begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_load_en || i_ack || w_alarm_expire) begin
            r_state     <= IDLE;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
          end else if (i_tick) begin
            r_alarm_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_running   <= 1'b0;
          r_alarm     <= 1'b0;
          r_alarm_cnt <= '0;
        end
      endcase
    end
  end

  assign o_running = r_running;
  assign o_alarm   = r_alarm;
  assign o_done_p  = r_done_p;
  assign o_zero    = w_zero;

endmodule
